// File: rtl/tube_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tube_write_arbiter
// Purpose  : Two-requester round-robin write arbiter for the seven-segment
//            tube peripheral, with a bounded exclusive lock for requester B
//            and screening of illegal byte-enable patterns.
// Revision : 1.0 - initial release
// ============================================================================
module tube_write_arbiter #(
  parameter int unsigned LOCK_MAX = 255
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req_a,
  input  logic        Addr_a,
  input  logic [3:0]  Be_a,
  input  logic [31:0] Wd_a,
  output logic        Gnt_a,
  input  logic        Req_b,
  input  logic        Addr_b,
  input  logic [3:0]  Be_b,
  input  logic [31:0] Wd_b,
  input  logic        Lock_b,
  output logic        Gnt_b,
  output logic        Tube_We,
  output logic        Tube_Addr,
  output logic [3:0]  Tube_Be,
  output logic [31:0] Tube_Wd,
  output logic        Locked,
  output logic        Be_err,
  output logic        Lock_err
);

  localparam int unsigned     CW         = (LOCK_MAX < 1) ? 1 : $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0]   C_LOCK_MAX = CW'(LOCK_MAX);
  localparam logic [CW-1:0]   C_CNT_ONE  = CW'(1);
  localparam logic [0:0]      S_IDLE     = 1'b0;
  localparam logic [0:0]      S_LOCKED_B = 1'b1;

  logic [0:0]    r_state;
  logic [0:0]    w_next_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          r_rr_last_b;
  logic          w_exit;
  logic          w_force_rel;
  logic          w_elig_a;
  logic          w_elig_b;
  logic          w_gnt_a;
  logic          w_gnt_b;
  logic          w_be_legal;
  logic [3:0]    w_sel_be;

  function automatic logic f_be_legal(input logic [3:0] be);
    case (be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: f_be_legal = 1'b1;
      default:                   f_be_legal = 1'b0;
    endcase
  endfunction

  // State register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next state and lock counter: enter on a locking B grant, leave when
  // Lock_b drops or when the counter would reach zero on this edge
  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    w_exit       = 1'b0;
    w_force_rel  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_gnt_b && Lock_b) begin
          w_next_state = S_LOCKED_B;
          w_cnt_next   = C_LOCK_MAX;
        end
      end
      S_LOCKED_B: begin
        w_cnt_next = r_cnt - C_CNT_ONE;
        if (!Lock_b) begin
          w_next_state = S_IDLE;
          w_exit       = 1'b1;
          w_cnt_next   = '0;
        end else if (r_cnt == C_CNT_ONE) begin
          w_next_state = S_IDLE;
          w_exit       = 1'b1;
          w_force_rel  = 1'b1;
          w_cnt_next   = '0;
        end
      end
      default: begin
        w_next_state = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Grant decision: a requester is blocked on the edge its own grant is high;
  // A is shut out while locked; contention goes to the one not granted last
  always_comb begin
    w_elig_a   = Req_a && !Gnt_a && (r_state == S_IDLE);
    w_elig_b   = Req_b && !Gnt_b;
    w_gnt_a    = w_elig_a && (!w_elig_b || r_rr_last_b);
    w_gnt_b    = w_elig_b && !w_gnt_a;
    w_sel_be   = w_gnt_b ? Be_b : Be_a;
    w_be_legal = f_be_legal(w_sel_be);
    Locked     = (r_state == S_LOCKED_B);
  end

  // Registered grant pulses, tube payload, sticky errors, rr pointer, counter
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Gnt_a       <= 1'b0;
      Gnt_b       <= 1'b0;
      Tube_We     <= 1'b0;
      Tube_Addr   <= 1'b0;
      Tube_Be     <= 4'b0000;
      Tube_Wd     <= 32'h0;
      Be_err      <= 1'b0;
      Lock_err    <= 1'b0;
      r_rr_last_b <= 1'b1;
      r_cnt       <= '0;
    end else begin
      Gnt_a   <= w_gnt_a;
      Gnt_b   <= w_gnt_b;
      Tube_We <= (w_gnt_a || w_gnt_b) && w_be_legal;
      r_cnt   <= w_cnt_next;
      if (w_gnt_a) begin
        Tube_Addr <= Addr_a;
        Tube_Be   <= Be_a;
        Tube_Wd   <= Wd_a;
      end else if (w_gnt_b) begin
        Tube_Addr <= Addr_b;
        Tube_Be   <= Be_b;
        Tube_Wd   <= Wd_b;
      end
      if ((w_gnt_a || w_gnt_b) && !w_be_legal) Be_err <= 1'b1;
      if (w_force_rel) Lock_err <= 1'b1;
      // Leaving the lock hands the next contention to A
      if (w_exit || w_gnt_b) r_rr_last_b <= 1'b1;
      else if (w_gnt_a)      r_rr_last_b <= 1'b0;
    end
  end

endmodule
`default_nettype wire
